// File: rtl/rr_arbiter_pkg.sv
// Shared types and elaboration helpers for the round-robin arbiter.
package rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Binary index of a one-hot vector of up to 64 bits; zero input yields 0.
  function automatic logic [5:0] oh2bin(input logic [63:0] oh);
    logic [5:0] b;
    b = '0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) b = b | 6'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority pick: first set bit of v scanning from
// position p upward, wrapping modulo N. Works for non-power-of-two N.
module rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] v,
  input  logic [W-1:0] p,
  output logic [N-1:0] gnt,
  output logic         found
);

  logic [N-1:0] v_rot;
  logic [N-1:0] g_rot;

  // Doubling the vector turns a modulo-N rotate into a plain shift.
  always_comb begin
    v_rot = N'({v, v} >> p);
    g_rot = v_rot & (~v_rot + N'(1));
    gnt   = N'(({g_rot, g_rot} << p) >> N);
    found = |v;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with grant locking until release.
// Optional tenure limit enabled by defining RR_ARBITER_MAXHOLD_EN.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int MAXHOLD = 16,
  localparam int W       = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_vld
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  state_e       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] grant_q, grant_d;

  logic [N-1:0] r_other;
  logic [N-1:0] gnt_idle, gnt_hand;
  logic         found_idle, found_hand;
  logic [W-1:0] nxt_ptr;
  logic         owner_req;
  logic         hold_expired;
  logic         end_tenure;
  logic         load_grant;

  assign owner_req = |(req & grant_q);
  assign r_other   = req & ~grant_q;
  assign nxt_ptr   = (idx_q == LAST_IDX) ? '0 : idx_q + W'(1);

  rr_pick #(.N(N), .W(W)) u_pick_idle (
    .v     (req),
    .p     (ptr_q),
    .gnt   (gnt_idle),
    .found (found_idle)
  );

  rr_pick #(.N(N), .W(W)) u_pick_hand (
    .v     (r_other),
    .p     (nxt_ptr),
    .gnt   (gnt_hand),
    .found (found_hand)
  );

`ifdef RR_ARBITER_MAXHOLD_EN
  localparam int            CW        = (MAXHOLD > 1) ? clog2(MAXHOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAXHOLD - 1);

  logic [CW-1:0] hold_q, hold_d;

  // Forced handover only when someone else is actually waiting.
  assign hold_expired = (hold_q == HOLD_LAST) && found_hand;

  always_comb begin
    hold_d = hold_q;
    if (load_grant) begin
      hold_d = '0;
    end else if (state_q == ST_BUSY && hold_q != HOLD_LAST) begin
      hold_d = hold_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  localparam int unused_maxhold = MAXHOLD;
  assign hold_expired = 1'b0;
`endif

  assign end_tenure = rel | ~owner_req | hold_expired;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    grant_d    = grant_q;
    load_grant = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (found_idle) begin
          grant_d    = gnt_idle;
          idx_d      = W'(oh2bin(64'(gnt_idle)));
          state_d    = ST_BUSY;
          load_grant = 1'b1;
        end
      end
      ST_BUSY: begin
        // The releasing owner is excluded from r_other, so it cannot win again here.
        if (end_tenure) begin
          ptr_d = nxt_ptr;
          if (found_hand) begin
            grant_d    = gnt_hand;
            idx_d      = W'(oh2bin(64'(gnt_hand)));
            load_grant = 1'b1;
          end else begin
            grant_d = '0;
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign grant_vld = (state_q == ST_BUSY);

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (N=8): directed steps push expected grants,
// a monitor pops and compares after each rising edge.
module tb_rr_arbiter;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rel = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic [W-1:0] grant_idx;
  logic         grant_vld;

  typedef struct {
    logic [N-1:0] g;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t         mon_e;
  logic [W-1:0] mon_idx;

  rr_arbiter #(.N(N), .MAXHOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rel       (rel),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and record the grant expected after the next edge.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic rl,
                      input logic [N-1:0] eg, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    rel = rl;
    e.g    = eg;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  always begin
    @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_idx = '0;
      for (int i = 0; i < N; i++) begin
        if (mon_e.g[i]) mon_idx = W'(i);
      end
      n_cmp++;
      if (grant !== mon_e.g || grant_idx !== mon_idx || grant_vld !== (|mon_e.g)) begin
        n_bad++;
        $display("FAIL %s: got grant=%h idx=%0d vld=%b, required grant=%h idx=%0d vld=%b",
                 mon_e.name, grant, grant_idx, grant_vld, mon_e.g, mon_idx, |mon_e.g);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    // Reset held with all requests asserted, then first grant one cycle later
    step(1'b1, 8'hFF, 1'b0, 8'h00, "reset_hold0");
    step(1'b1, 8'hFF, 1'b0, 8'h00, "reset_hold1");
    step(1'b0, 8'hFF, 1'b0, 8'h01, "first_grant");

    // Rotation with zero-bubble handover, wrapping back to 0
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'hFF, 1'b1, 8'(1 << (i % 8)), "rotation");
    end

    // Reach requester 5, lock, then drop its request
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 8'hFF, 1'b1, 8'(1 << i), "reach_5");
    end
`ifndef RR_ARBITER_MAXHOLD_EN
    repeat (20) step(1'b0, 8'hFF, 1'b0, 8'h20, "lock");
`endif
    step(1'b0, 8'hDF, 1'b0, 8'h40, "drop_owner_req");

    // Sparse wrap and pointer after going idle
    step(1'b0, 8'hFF, 1'b1, 8'h80, "to_owner7");
    step(1'b0, 8'h81, 1'b1, 8'h01, "wrap_7_to_0");
    step(1'b0, 8'h01, 1'b1, 8'h00, "release_to_idle");
    step(1'b0, 8'hFF, 1'b0, 8'h02, "idle_ptr_is_1");
    step(1'b0, 8'hFD, 1'b1, 8'h04, "rel_and_drop");

    // Reset mid-tenure clears grant and pointer
    step(1'b0, 8'hFF, 1'b1, 8'h08, "to_owner3");
    step(1'b0, 8'hFF, 1'b0, 8'h08, "owner3_hold");
    step(1'b1, 8'hFF, 1'b0, 8'h00, "mid_reset0");
    step(1'b1, 8'hFF, 1'b0, 8'h00, "mid_reset1");
    step(1'b0, 8'h18, 1'b0, 8'h08, "post_reset_pick3");
    step(1'b0, 8'h18, 1'b1, 8'h10, "handover_4");
    step(1'b0, 8'h10, 1'b1, 8'h00, "idle_ptr5");
    step(1'b0, 8'h18, 1'b0, 8'h08, "circular_from5");
    step(1'b0, 8'h00, 1'b0, 8'h00, "drop_all");
    step(1'b0, 8'h00, 1'b0, 8'h00, "idle_stay");

`ifdef RR_ARBITER_MAXHOLD_EN
    step(1'b1, 8'h00, 1'b0, 8'h00, "mh_reset");
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 8'h03, 1'b0, (((k / 4) % 2) == 0) ? 8'h01 : 8'h02, "maxhold_alt");
    end
    repeat (10) step(1'b0, 8'h01, 1'b0, 8'h01, "maxhold_solo");
`endif

    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Registered round-robin arbiter with grant locking.
- Parametrised, sequential successor to the fixed-priority arbiter in the building-block library. Unlike that arbiter, priority rotates, so no requester starves.
- N requesters share one resource. A winner holds its grant until it releases.
- Sits in front of shared buses, memory ports and output channels.

Parameters:
- N, 8, number of requesters; N >= 2.
- W, $clog2(N), width of the grant index; derived, not overridden.
- MAXHOLD, 16, maximum tenure in cycles; used only when RR_ARBITER_MAXHOLD_EN is defined; MAXHOLD >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i is high while requester i wants or holds the resource.
- rel  input  1  current owner finishes this cycle; ignored when there is no owner.
- grant  output  N  registered one-hot grant, or all zero.
- grant_idx  output  W  binary index of the granted requester; 0 when grant_vld=0.
- grant_vld  output  1  high when grant is non-zero.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - On rst: grant=0, grant_idx=0, grant_vld=0, state=IDLE, ptr=0, hold counter=0.
  - rst has priority over every other event. A grant in flight is dropped at the next edge with no release handshake.
- State:
  - ptr: W-bit pointer to the highest-priority requester.
  - owner: equals grant_idx.
  - FSM states: IDLE (no owner) and BUSY (owner locked).
- pick(v, p): first index i with v[i]=1, scanning p, p+1, ..., N-1, 0, ..., p-1 (modulo N).
- IDLE:
  - If |req: grant <= onehot(pick(req, ptr)), state <= BUSY.
  - Otherwise remain in IDLE.
  - Latency from request to grant is exactly 1 cycle.
- BUSY, end-of-tenure condition E = rel | ~req[owner].
  - With the optional feature, E also includes the hold-limit expiry described below.
  - E=0: grant, grant_idx and ptr hold.
  - E=1:
    - ptr <= (owner+1) mod N.
    - Let r' = req & ~onehot(owner).
    - If |r': grant <= onehot(pick(r', (owner+1) mod N)) and state stays BUSY. Handover has zero bubble cycles.
    - If r' is zero: grant <= 0, state <= IDLE.
    - The old owner is never re-granted on the cycle it releases, even if its req stays high.
- Wrap-around:
  - When owner=N-1, the pointer returns to 0.
  - The scan is circular, so requester 0 can win immediately after N-1.
- Simultaneous events:
  - rel together with owner deasserting req is a single release.
  - New requests arriving during BUSY wait; they are considered at the next release.
- Guarantees:
  - grant is always one-hot or zero.
  - grant only ever points at a requester whose req was high in the cycle before the grant was registered.
- Arithmetic: all index arithmetic is modulo N. N need not be a power of two.

Optional Feature:
- Macro: RR_ARBITER_MAXHOLD_EN.
- Defined:
  - A hold counter is cleared on every new grant and increments each BUSY cycle, saturating at MAXHOLD-1.
  - When the counter equals MAXHOLD-1 and another requester is waiting (|r'), E is forced to 1 and the grant moves to the next requester.
  - With no competing requester, the owner keeps the grant indefinitely and the counter stays saturated.
- Undefined: no counter logic exists, MAXHOLD is ignored, and tenure is unbounded.

Decomposition:
- Package rr_arbiter_pkg holds:
  - state encoding constants ST_IDLE=1'b0 and ST_BUSY=1'b1;
  - a clog2 function;
  - a onehot-to-binary function for up to 64 inputs.
- Sub-module rr_pick: purely combinational pick(v, p).
  - Rotate v right by p, apply a fixed-priority carry-chain arbiter, then rotate the result back left by p.
  - Outputs a one-hot vector plus a found flag.
  - rr_arbiter instantiates rr_pick twice: one for IDLE/req and one for handover/r'.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req=8'hFF → grant=0 and grant_vld=0 throughout. Release rst → one cycle later grant=8'h01 and grant_idx=0.
2. Rotation: req=8'hFF held, rel pulsed every cycle → grant_idx sequence 0,1,2,...,7,0, with no zero-grant cycles between owners.
3. Lock: requester 5 granted, req=8'hFF, rel=0 for 20 cycles (macro undefined) → grant stays 8'h20. Then drop req[5] → next cycle grant=8'h40.
4. Sparse wrap: req=8'h81, owner=7 releases → grant=8'h01. Owner 0 releases with req=8'h01 only → grant=0, IDLE, ptr=1.
5. Reset mid-tenure: owner=3 in BUSY, assert rst → next edge grant=0 and ptr=0. Next grant with req=8'h18 is index 3.
6. With RR_ARBITER_MAXHOLD_EN, MAXHOLD=4, req=8'h03, rel=0 → grant alternates 0,1,0,1, switching every 4 cycles. With req=8'h01 only, grant=8'h01 persists.
